// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronises the pins, deframes scancodes and buffers them for a CPU register interface.
// Optional macro PS2_BREAK_FILTER_EN folds the 0xF0 break prefix into bit 8 of the following FIFO entry.
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        reg_sel,
  input  logic        reg_wenable,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

`ifdef PS2_BREAK_FILTER_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_ok_q, parity_ok_d;
  logic            brk_q, brk_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d, parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d, enable_q, enable_d, irq_en_q, irq_en_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;
  logic [8:0]      fifo_mem [FIFO_DEPTH];

  logic            fall, push_req, push_ok, pop, set_perr, set_ferr;
  logic            rd_req, wr_req, fifo_empty, fifo_full;
  logic [8:0]      push_data;
  logic [2:0]      status_w1c;
  logic            unused_wdata;

  assign fall         = clk_prev_q & ~clk_s2_q;
  assign rd_req       = reg_sel & ~reg_wenable;
  assign wr_req       = reg_sel & reg_wenable;
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == DEPTH_C);
  assign unused_wdata = ^reg_wdata[31:5];
  assign reg_rdata    = rdata_q;
  assign irq          = irq_q;

  // Frame FSM; the timeout counter saturates so a long idle line costs nothing.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    brk_d       = brk_q;
    push_req    = 1'b0;
    push_data   = '0;
    set_perr    = 1'b0;
    set_ferr    = 1'b0;
    tmo_d       = fall ? '0 : ((tmo_q == TMO_C) ? tmo_q : tmo_q + 1'b1);
    if (!enable_q) begin
      state_d = S_IDLE;
      brk_d   = 1'b0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_ok_d = ^{shift_q, dat_s2_q};
          state_d     = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && parity_ok_q) begin
            if (BRK_EN && (shift_q == 8'hF0)) begin
              brk_d = 1'b1;
            end else begin
              push_req  = 1'b1;
              push_data = {brk_q & BRK_EN, shift_q};
              brk_d     = 1'b0;
            end
          end else begin
            set_perr = ~parity_ok_q;
            set_ferr = ~dat_s2_q;
            brk_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && (tmo_q == TMO_C)) begin
      state_d  = S_IDLE;
      set_ferr = 1'b1;
      brk_d    = 1'b0;
    end
  end

  // FIFO bookkeeping and register file; a pop in the same cycle frees a slot for a push.
  always_comb begin
    pop        = rd_req && (reg_addr == ADDR_DATA) && !fifo_empty;
    push_ok    = push_req && (!fifo_full || pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    status_w1c   = (wr_req && (reg_addr == ADDR_STATUS)) ? reg_wdata[4:2] : 3'b000;
    overflow_d   = (overflow_q & ~status_w1c[0]) | (push_req & ~push_ok);
    parity_err_d = (parity_err_q & ~status_w1c[1]) | set_perr;
    frame_err_d  = (frame_err_q & ~status_w1c[2]) | set_ferr;
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    if (wr_req && (reg_addr == ADDR_CTRL)) begin
      enable_d = reg_wdata[0];
      irq_en_d = reg_wdata[1];
    end
    rdata_d = rdata_q;
    if (rd_req) begin
      case (reg_addr)
        ADDR_DATA:   rdata_d = fifo_empty ? 32'd0 : {23'd0, fifo_mem[rd_ptr_q]};
        ADDR_STATUS: rdata_d = {16'd0, 8'(count_q), 3'd0, frame_err_q, parity_err_q,
                                overflow_q, fifo_full, ~fifo_empty};
        ADDR_CTRL:   rdata_d = {30'd0, irq_en_q, enable_q};
        default:     rdata_d = 32'd0;
      endcase
    end
    irq_d = irq_en_q & ~fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      parity_ok_q  <= 1'b0;
      brk_q        <= 1'b0;
      tmo_q        <= '0;
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      enable_q     <= 1'b1;
      irq_en_q     <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      parity_ok_q  <= parity_ok_d;
      brk_q        <= brk_d;
      tmo_q        <= tmo_d;
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      clk_prev_q   <= clk_s2_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a transaction-level model of the FIFO/flags/registers
// checked every cycle against reg_rdata and irq, plus literal expectations from hand-worked frames.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

  localparam int HALF  = 40;
  localparam int DEPTH = 8;
  localparam int TMO   = 20000;
  localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_CTRL = 4'h8;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ps2_clk = 1'b1, ps2_data = 1'b1;
  logic        reg_sel = 1'b0, reg_wenable = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;
  logic        irq;

  ps2_kbd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .reg_sel(reg_sel), .reg_wenable(reg_wenable), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq)
  );

  // model state
  logic [8:0]  exp_q[$];
  logic        m_ovf = 0, m_perr = 0, m_ferr = 0, m_en = 1, m_irq_en = 0, m_brk = 0;
  logic [31:0] exp_rdata = 32'd0;
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, quiet_until = 0;
  bit          run_chk = 0;
  logic [31:0] rd_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      check("rdata_track", reg_rdata, exp_rdata);
      if (cyc >= quiet_until)
        check("irq_track", {31'd0, irq}, {31'd0, m_irq_en && (exp_q.size() != 0)});
    end
  end

  task automatic m_reset();
    exp_q.delete();
    m_ovf = 0; m_perr = 0; m_ferr = 0; m_en = 1; m_irq_en = 0; m_brk = 0;
    exp_rdata = 32'd0;
  endtask

  task automatic m_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok);
    logic [8:0] val;
    if (!m_en) return;
    if (par_ok && stop_ok) begin
`ifdef PS2_BREAK_FILTER_EN
      if (b == 8'hF0) begin
        m_brk = 1;
        return;
      end
      val = {m_brk, b};
      m_brk = 0;
`else
      val = {1'b0, b};
`endif
      if (exp_q.size() < DEPTH) exp_q.push_back(val);
      else m_ovf = 1;
    end else begin
      if (!par_ok) m_perr = 1;
      if (!stop_ok) m_ferr = 1;
      m_brk = 0;
    end
  endtask

  task automatic m_read(input logic [3:0] a, output logic [31:0] e);
    int n;
    n = exp_q.size();
    case (a)
      A_DATA:   e = (n != 0) ? {23'd0, exp_q.pop_front()} : 32'd0;
      A_STATUS: e = {16'd0, 8'(n), 3'd0, m_ferr, m_perr, m_ovf, 1'(n == DEPTH), 1'(n != 0)};
      A_CTRL:   e = {30'd0, m_irq_en, m_en};
      default:  e = 32'd0;
    endcase
  endtask

  // driver tasks
  task automatic bus_read(input logic [3:0] a, output logic [31:0] act);
    logic [31:0] e;
    @(negedge clk);
    reg_sel = 1; reg_wenable = 0; reg_addr = a; reg_wdata = 32'd0;
    m_read(a, e);
    @(posedge clk); #1;
    reg_sel = 0;
    exp_rdata = e;
    act = reg_rdata;
    if (quiet_until < cyc + 4) quiet_until = cyc + 4;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_sel = 1; reg_wenable = 1; reg_addr = a; reg_wdata = d;
    if (a == A_STATUS) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_perr = 0;
      if (d[4]) m_ferr = 0;
    end else if (a == A_CTRL) begin
      m_en = d[0]; m_irq_en = d[1];
      if (!d[0]) m_brk = 0;
    end
    @(posedge clk); #1;
    reg_sel = 0; reg_wenable = 0;
    if (quiet_until < cyc + 4) quiet_until = cyc + 4;
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1;
  endtask

  // mode 1: STATUS read 3 cycles after the stop edge; mode 2: DATA read landing in the push cycle
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b,
                            input int mode, output logic [31:0] side_v);
    logic [10:0] bits;
    bits = {stop_b, (~^b) ^ par_flip, b, 1'b0};
    side_v = 32'd0;
    quiet_until = 32'h7fff_ffff;
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    @(negedge clk);
    ps2_data = stop_b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 0;
    if (mode == 2) begin
      @(negedge clk);
      bus_read(A_DATA, side_v);
      m_frame(b, ~par_flip, stop_b);
    end else begin
      m_frame(b, ~par_flip, stop_b);
      if (mode == 1) begin
        repeat (2) @(negedge clk);
        bus_read(A_STATUS, side_v);
      end
    end
    quiet_until = 32'h7fff_ffff;
    repeat (HALF - 6) @(negedge clk);
    ps2_clk = 1;
    repeat (4) @(negedge clk);
    quiet_until = cyc + 3;
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] bits;
    bits = {1'b1, ~^b, b, 1'b0};
    quiet_until = 32'h7fff_ffff;
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 0;
    ps2_clk = 1; ps2_data = 1;
    m_reset();
    repeat (3) @(negedge clk);
    check("rdata_in_reset", reg_rdata, 32'd0);
    check("irq_in_reset", {31'd0, irq}, 32'd0);
    #2 rst_n = 1;
    quiet_until = cyc + 2;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sv;
    logic [7:0] drain [8];
    drain = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

    do_reset();
    run_chk = 1;
    bus_read(A_STATUS, rd_v); check("reset_status", rd_v, 32'h0);
    bus_read(A_CTRL, rd_v);   check("reset_ctrl", rd_v, 32'h1);
    bus_read(A_DATA, rd_v);   check("reset_data_empty", rd_v, 32'h0);

    // 0x15, parity bit 0, status sampled shortly after the stop edge
    send_frame(8'h15, 0, 1, 1, sv);
    check("early_status", sv, 32'h0000_0101);
    bus_read(A_DATA, rd_v);   check("data_15", rd_v, 32'h015);
    bus_read(A_STATUS, rd_v); check("status_after_pop", rd_v, 32'h0);
    check("irq_idle", {31'd0, irq}, 32'd0);

    // irq path
    bus_write(A_CTRL, 32'h3);
    send_frame(8'h1C, 0, 1, 0, sv);
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_read(A_DATA, rd_v);   check("data_1c", rd_v, 32'h01C);
    @(posedge clk); #1;
    check("irq_clear", {31'd0, irq}, 32'd0);

    // parity error
    send_frame(8'h15, 1, 1, 0, sv);
    bus_read(A_STATUS, rd_v); check("status_perr", rd_v, 32'h08);
    bus_write(A_STATUS, 32'h08);
    bus_read(A_STATUS, rd_v); check("status_perr_clr", rd_v, 32'h0);

    // overflow, then push/pop in the same cycle on a full FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 0, sv);
    bus_read(A_STATUS, rd_v); check("status_ovf", rd_v, 32'h0000_0807);
    bus_write(A_STATUS, 32'h04);
    bus_read(A_STATUS, rd_v); check("status_full", rd_v, 32'h0000_0803);
    send_frame(8'h0A, 0, 1, 2, sv);
    check("pop_during_push", sv, 32'h001);
    bus_read(A_STATUS, rd_v); check("status_full_again", rd_v, 32'h0000_0803);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_DATA, rd_v); check("drain", rd_v, {24'd0, drain[i]});
    end
    bus_read(A_DATA, rd_v);   check("drain_empty", rd_v, 32'h0);
    bus_read(A_STATUS, rd_v); check("status_drained", rd_v, 32'h0);

    // timeout of a partial frame
    send_partial(8'h1C, 4);
    repeat (TMO + 10) @(negedge clk);
    m_ferr = 1; m_brk = 0;
    quiet_until = cyc + 3;
    bus_read(A_STATUS, rd_v); check("status_timeout", rd_v, 32'h10);
    bus_write(A_STATUS, 32'h10);
    send_frame(8'h1C, 0, 1, 0, sv);
    bus_read(A_DATA, rd_v);   check("data_after_timeout", rd_v, 32'h01C);

    // stop-bit error, then both faults
    send_frame(8'h44, 0, 0, 0, sv);
    bus_read(A_STATUS, rd_v); check("status_ferr", rd_v, 32'h10);
    send_frame(8'h44, 1, 0, 0, sv);
    bus_read(A_STATUS, rd_v); check("status_both", rd_v, 32'h18);
    bus_write(A_STATUS, 32'h1C);
    bus_read(A_STATUS, rd_v); check("status_w1c_all", rd_v, 32'h0);

    // receiver disabled
    bus_write(A_CTRL, 32'h0);
    send_frame(8'h33, 0, 1, 0, sv);
    bus_read(A_STATUS, rd_v); check("status_disabled", rd_v, 32'h0);
    bus_read(A_CTRL, rd_v);   check("ctrl_disabled", rd_v, 32'h0);
    bus_write(A_CTRL, 32'h3);

    // break prefix
    send_frame(8'hF0, 0, 1, 0, sv);
    send_frame(8'h1C, 0, 1, 0, sv);
`ifdef PS2_BREAK_FILTER_EN
    bus_read(A_STATUS, rd_v); check("brk_status", rd_v, 32'h0000_0101);
    bus_read(A_DATA, rd_v);   check("brk_entry", rd_v, 32'h11C);
    send_frame(8'h1C, 0, 1, 0, sv);
`else
    bus_read(A_STATUS, rd_v); check("brk_status", rd_v, 32'h0000_0201);
    bus_read(A_DATA, rd_v);   check("brk_entry", rd_v, 32'h0F0);
`endif
    check("irq_before_reset", {31'd0, irq}, 32'd1);

    // reset in the middle of a frame
    send_partial(8'h5A, 4);
    do_reset();
    bus_read(A_STATUS, rd_v); check("post_reset_status", rd_v, 32'h0);
    bus_read(A_CTRL, rd_v);   check("post_reset_ctrl", rd_v, 32'h1);
    bus_read(A_DATA, rd_v);   check("post_reset_data", rd_v, 32'h0);
    send_frame(8'h5A, 0, 1, 0, sv);
    bus_read(A_DATA, rd_v);   check("data_after_reset", rd_v, 32'h05A);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
